// File: rtl/fb_pkg.sv
// fb_pkg: shared widths and write-buffer entry type for the frame-buffer arbiter
package fb_pkg;
  localparam int FB_LINE_W  = 9;
  localparam int FB_PIXEL_W = 10;
  localparam int FB_DATA_W  = 12;
  localparam int FB_ADDR_W  = FB_LINE_W + FB_PIXEL_W;
  localparam int FB_DROP_W  = 8;
  typedef struct packed {
    logic [FB_LINE_W-1:0]  line;
    logic [FB_PIXEL_W-1:0] pixel;
    logic [FB_DATA_W-1:0]  data;
  } wr_entry_t;
endpackage

// File: rtl/fb_wbuf.sv
// fb_wbuf: synchronous FIFO; head shows the oldest entry while not empty
module fb_wbuf #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign head    = mem_q[rd_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) mem_q[wr_q] <= din;
      wr_q  <= wr_q + AW'(push_ok);
      rd_q  <= rd_q + AW'(pop_ok);
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port frame RAM between buffered camera writes
// and prioritized display reads, with a bound on how long a write can be starved.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int CAM_DATA_WIDTH = FB_DATA_W,
  parameter int CAM_LINE       = FB_LINE_W,
  parameter int CAM_PIXEL      = FB_PIXEL_W,
  parameter int WBUF_DEPTH     = 4,
  parameter int MAX_WAIT       = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cfg_done,
  input  logic                          w_we,
  input  logic [CAM_LINE-1:0]           w_line,
  input  logic [CAM_PIXEL-1:0]          w_pixel,
  input  logic [CAM_DATA_WIDTH-1:0]     w_data,
  input  logic                          r_valid,
  output logic                          r_ready,
  input  logic [CAM_LINE-1:0]           r_line,
  input  logic [CAM_PIXEL-1:0]          r_pixel,
  output logic                          r_dvalid,
  output logic [CAM_DATA_WIDTH-1:0]     r_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [CAM_LINE+CAM_PIXEL-1:0] mem_addr,
  output logic [CAM_DATA_WIDTH-1:0]     mem_wdata,
  input  logic [CAM_DATA_WIDTH-1:0]     mem_rdata,
  output logic                          wbuf_ovf,
  output logic [FB_DROP_W-1:0]          drop_cnt
);
  wr_entry_t                      w_ent, head;
  logic                           full, empty, starve, grant_w, grant_r, push, drop;
  logic [7:0]                     wait_q, wait_d;
  logic                           mem_en_q, mem_we_q, rd2_q, r_dvalid_q, ovf_q;
  logic [CAM_LINE+CAM_PIXEL-1:0]  mem_addr_q, mem_addr_d;
  logic [CAM_DATA_WIDTH-1:0]      mem_wdata_q, mem_wdata_d, r_data_q, r_data_d;
  logic [FB_DROP_W-1:0]           drop_q, drop_d;

  assign w_ent = {w_line, w_pixel, w_data};

  fb_wbuf #(.DEPTH(WBUF_DEPTH), .W($bits(wr_entry_t))) u_wbuf (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(grant_w), .din(w_ent),
    .head(head), .full(full), .empty(empty)
  );

  // Grants are held off while in reset so no RAM op or r_ready leaks out of it.
  assign starve  = ~empty & (wait_q >= 8'(MAX_WAIT));
  assign grant_w = reset_n & ~empty & (starve | ~r_valid);
  assign grant_r = reset_n & r_valid & ~grant_w;
  assign r_ready = grant_r;
  assign push    = w_we & cfg_done & (~full | grant_w);
  assign drop    = w_we & cfg_done & full & ~grant_w;

  always_comb begin
    wait_d      = (grant_w | empty) ? '0 : (grant_r && wait_q != '1) ? wait_q + 8'd1 : wait_q;
    mem_addr_d  = grant_w ? {head.line, head.pixel} : grant_r ? {r_line, r_pixel} : mem_addr_q;
    mem_wdata_d = grant_w ? head.data : grant_r ? '0 : mem_wdata_q;
    r_data_d    = rd2_q ? mem_rdata : r_data_q;
    drop_d      = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
  end

  // rd2_q marks the cycle the RAM's registered read data is presented.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd2_q       <= 1'b0;
      r_dvalid_q  <= 1'b0;
      r_data_q    <= '0;
      drop_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      mem_en_q    <= grant_w | grant_r;
      mem_we_q    <= grant_w;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd2_q       <= mem_en_q & ~mem_we_q;
      r_dvalid_q  <= rd2_q;
      r_data_q    <= r_data_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_q | drop;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign r_dvalid  = r_dvalid_q;
  assign r_data    = r_data_q;
  assign wbuf_ovf  = ovf_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed and random stimulus against a queue-based model of the arbiter.
module tb_fb_port_arbiter;
  localparam int DW = 12, LW = 9, PW = 10, AW = LW + PW, DEPTH = 4, MAXW = 8;

  logic          clk = 1'b0, reset_n = 1'b0, cfg_done = 1'b0, w_we = 1'b0, r_valid = 1'b0;
  logic [LW-1:0] w_line = '0, r_line = '0;
  logic [PW-1:0] w_pixel = '0, r_pixel = '0;
  logic [DW-1:0] w_data = '0, mem_rdata = '0;
  logic          r_ready, r_dvalid, mem_en, mem_we, wbuf_ovf;
  logic [DW-1:0] r_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [7:0]    drop_cnt;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  fb_port_arbiter #(.CAM_DATA_WIDTH(DW), .CAM_LINE(LW), .CAM_PIXEL(PW),
                    .WBUF_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_done(cfg_done), .w_we(w_we), .w_line(w_line),
    .w_pixel(w_pixel), .w_data(w_data), .r_valid(r_valid), .r_ready(r_ready),
    .r_line(r_line), .r_pixel(r_pixel), .r_dvalid(r_dvalid), .r_data(r_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .wbuf_ovf(wbuf_ovf), .drop_cnt(drop_cnt)
  );

  // Stimulus keeps lines < 32 and pixels < 32, so this fold never aliases.
  function automatic int fold(input logic [AW-1:0] a);
    return int'({a[14:10], a[4:0]});
  endfunction

  function automatic logic [DW-1:0] init_val(input int k);
    return DW'(k * 37 + 'h15);
  endfunction

  logic [DW-1:0] ram [1024];
  bit            ram_wr [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[fold(mem_addr)]    <= mem_wdata;
        ram_wr[fold(mem_addr)] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[fold(mem_addr)] ? ram[fold(mem_addr)] : init_val(fold(mem_addr));
      end
    end
  end

  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0]    gold [1024];
  int               m_wait = 0, m_drop = 0;
  bit               m_ovf = 0, e_en = 0, e_we = 0, last_rr = 0;
  logic [AW-1:0]    e_addr = '0;
  logic [DW-1:0]    e_wdata = '0, e_rdata = '0;
  bit               dv [3];
  logic [DW-1:0]    dd [3];
  int               dv_seen = 0, we_seen = 0, sidx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit cfg, input bit we, input int wl, input int wp,
                      input int wd, input bit rv, input int rl, input int rp);
    logic [AW-1:0] ra, ha;
    logic [DW-1:0] hd;
    bit            emp, full, gw, gr;
    reset_n = !rst; cfg_done = cfg; w_we = we;
    w_line = LW'(wl); w_pixel = PW'(wp); w_data = DW'(wd);
    r_valid = rv; r_line = LW'(rl); r_pixel = PW'(rp);
    ra = {r_line, r_pixel};
    @(negedge clk);
    emp  = wq.size() == 0;
    full = wq.size() == DEPTH;
    {ha, hd} = emp ? '0 : wq[0];
    gw = !rst && !emp && (m_wait >= MAXW || !rv);
    gr = !rst && rv && !gw;
    if (dv[2]) e_rdata = dd[2];
    chk("r_ready", r_ready, gr);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("r_dvalid", r_dvalid, dv[2]);
    chk("r_data", r_data, e_rdata);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("wbuf_ovf", wbuf_ovf, m_ovf);
    last_rr = r_ready;
    if (r_dvalid) dv_seen++;
    if (mem_en && mem_we) we_seen++;
    dv[2] = dv[1]; dd[2] = dd[1];
    dv[1] = dv[0]; dd[1] = dd[0];
    dv[0] = gr;    dd[0] = gold[fold(ra)];
    if (rst) begin
      wq.delete();
      m_wait = 0; m_drop = 0; m_ovf = 0;
      dv[0] = 0; dv[1] = 0; dv[2] = 0;
      e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    end else begin
      e_en = gw || gr;
      e_we = gw;
      if (gw) begin
        e_addr = ha; e_wdata = hd;
        gold[fold(ha)] = hd;
        void'(wq.pop_front());
      end else if (gr) begin
        e_addr = ra; e_wdata = '0;
      end
      m_wait = (gw || emp) ? 0 : (gr && m_wait < 255) ? m_wait + 1 : m_wait;
      if (we && cfg) begin
        if (!full || gw) wq.push_back({w_line, w_pixel, w_data});
        else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) gold[i] = init_val(i);
    for (int i = 0; i < 3; i++) begin dv[i] = 0; dd[i] = '0; end
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_r_dvalid", r_dvalid, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_ovf", wbuf_ovf, 0);
    chk("rst_drop", drop_cnt, 0);

    step(0, 0, 0, 0, 0, 0, 1, 3, 5);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    dv_seen = 0;
    repeat (4) idle();
    chk("rst_mid_read_no_dvalid", dv_seen, 0);

    dv_seen = 0;
    repeat (10) step(0, 0, 0, 0, 0, 0, 1, 3, 5);
    repeat (4) idle();
    chk("read_burst_dvalids", dv_seen, 10);

    we_seen = 0;
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, i, 'hA00 + i, 0, 0, 0);
    repeat (4) idle();
    chk("write_only_we_count", we_seen, 4);

    sidx = -1;
    for (int i = 0; i < 21; i++) begin
      step(0, 1, i == 0, 1, 9, 'h5C, 1, 2, i);
      if (!last_rr && sidx < 0) sidx = i;
    end
    chk("starve_write_slot", sidx, 9);
    repeat (4) idle();

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 2, i, 'h700 + i, 1, 4, i);
    chk("ovf_drop_two", drop_cnt, 2);
    chk("ovf_flag", wbuf_ovf, 1);
    for (int i = 0; i < 300; i++) step(0, 1, 1, 2, i % 8, i, 1, 4, i % 8);
    chk("ovf_drop_saturate", drop_cnt, 255);
    repeat (12) idle();

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    we_seen = 0;
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, i, 'h300 + i, 0, 0, 0);
    repeat (4) idle();
    chk("nocfg_no_we", we_seen, 0);
    chk("nocfg_drop", drop_cnt, 0);
    chk("nocfg_ovf", wbuf_ovf, 0);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), $urandom_range(0, 7), $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom_range(0, 7));
    repeat (5) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
